// File: rtl/jtag_pkg.sv
// Shared JTAG data-register constants: opcodes, DR lengths, memory geometry.
// The TAP's bypass wiring uses the same decode helper.
package jtag_pkg;

  localparam logic [3:0] IR_IDCODE   = 4'b0001;
  localparam logic [3:0] IR_USERDATA = 4'b0010;
  localparam logic [3:0] IR_MEMADDR  = 4'b0011;
  localparam logic [3:0] IR_MEMDATA  = 4'b0100;

  localparam int DR_LEN_IDCODE = 32;
  localparam int DR_LEN_USER   = 8;
  localparam int MEM_DEPTH     = 16;
  localparam int MEM_AW        = 4;
  localparam int MEM_DW        = 8;

  typedef enum logic [2:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USERDATA,
    DR_MEMADDR,
    DR_MEMDATA
  } dr_sel_e;

  function automatic dr_sel_e decode_ir(input logic [3:0] ir);
    dr_sel_e sel;
    case (ir)
      IR_IDCODE:   sel = DR_IDCODE;
      IR_USERDATA: sel = DR_USERDATA;
      IR_MEMADDR:  sel = DR_MEMADDR;
      IR_MEMDATA:  sel = DR_MEMDATA;
      default:     sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_dr_regs_if.sv
// TAP-to-data-register signal bundle; the TAP drives, the DR block responds.
interface jtag_dr_regs_if;
  logic [3:0] ir_i;
  logic       tdi_i;
  logic       capture_i;
  logic       shift_i;
  logic       update_i;
  logic       tdo_o;
  logic       bypass_o;

  modport master (output ir_i, tdi_i, capture_i, shift_i, update_i,
                  input  tdo_o, bypass_o);
  modport slave  (input  ir_i, tdi_i, capture_i, shift_i, update_i,
                  output tdo_o, bypass_o);
endinterface

// File: rtl/jtag_dr_mem.sv
// 16x8 debug memory with an auto-incrementing address counter.
// Only trst_ni clears the array; the synchronous clear touches the address alone.
module jtag_dr_mem
  import jtag_pkg::*;
(
  input  logic              tck_i,
  input  logic              trst_ni,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic              i_ld_addr,
  input  logic [MEM_DW-1:0] i_wdata,
  input  logic [MEM_AW-1:0] i_addr_d,
  output logic [MEM_AW-1:0] o_addr,
  output logic [MEM_DW-1:0] o_rdata
);

  logic [MEM_DW-1:0] r_mem [MEM_DEPTH];
  logic [MEM_AW-1:0] r_addr;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_addr <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_we) begin
      r_mem[r_addr] <= i_wdata;
      r_addr        <= r_addr + 1'b1;
    end else if (i_ld_addr) begin
      r_addr <= i_addr_d;
    end
  end

  assign o_addr  = r_addr;
  assign o_rdata = r_mem[r_addr];

endmodule

// File: rtl/jtag_dr_regs.sv
// JTAG data registers: IDCODE, USERDATA, MEMADDR, MEMDATA sharing one 32-bit
// shift register. Capture beats shift beats update; reset_i beats all three.
module jtag_dr_regs
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h1000_0CDF
) (
  input  logic                tck_i,
  input  logic                trst_ni,
  input  logic                reset_i,
  jtag_dr_regs_if.slave       tap,
  input  logic [7:0]          status_i,
  output logic [7:0]          data_o
);

  dr_sel_e           w_sel;
  logic              w_upd;
  logic              w_we;
  logic              w_ld_addr;
  logic [MEM_AW-1:0] w_addr;
  logic [MEM_DW-1:0] w_rdata;
  logic [31:0]       r_sr;
  logic [7:0]        r_data;

  assign w_sel        = decode_ir(tap.ir_i);
  assign tap.bypass_o = (w_sel == DR_BYPASS);
  assign tap.tdo_o    = tap.bypass_o ? 1'b0 : r_sr[0];

  assign w_upd     = tap.update_i & ~tap.capture_i & ~tap.shift_i & ~reset_i;
  assign w_we      = w_upd & (w_sel == DR_MEMDATA);
  assign w_ld_addr = w_upd & (w_sel == DR_MEMADDR);

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_sr   <= '0;
      r_data <= '0;
    end else if (reset_i) begin
      r_sr   <= '0;
      r_data <= '0;
    end else if (w_sel != DR_BYPASS) begin
      if (tap.capture_i) begin
        case (w_sel)
          DR_IDCODE:   r_sr      <= IDCODE;
          DR_USERDATA: r_sr[7:0] <= status_i;
          DR_MEMADDR:  r_sr[7:0] <= {4'b0000, w_addr};
          DR_MEMDATA:  r_sr[7:0] <= w_rdata;
          default:     ;
        endcase
      end else if (tap.shift_i) begin
        // 8-bit DRs shift only the low byte so stale upper bits never reach tdo
        if (w_sel == DR_IDCODE) r_sr      <= {tap.tdi_i, r_sr[31:1]};
        else                    r_sr[7:0] <= {tap.tdi_i, r_sr[7:1]};
      end else if (tap.update_i && w_sel == DR_USERDATA) begin
        r_data <= r_sr[7:0];
      end
    end
  end

  assign data_o = r_data;

  jtag_dr_mem u_mem (
    .tck_i     (tck_i),
    .trst_ni   (trst_ni),
    .i_clr     (reset_i),
    .i_we      (w_we),
    .i_ld_addr (w_ld_addr),
    .i_wdata   (r_sr[7:0]),
    .i_addr_d  (r_sr[3:0]),
    .o_addr    (w_addr),
    .o_rdata   (w_rdata)
  );

endmodule

// File: tb/tb_jtag_dr_regs.sv
// Scoreboard bench for jtag_dr_regs: scans push expected capture words, a
// negedge monitor reassembles tdo bits and compares against the queue.
module tb_jtag_dr_regs;

  localparam logic [31:0] IDCODE = 32'h1000_0CDF;

  logic       tck_i;
  logic       trst_ni;
  logic       reset_i;
  logic [7:0] status_i;
  logic [7:0] data_o;

  jtag_dr_regs_if tap ();

  jtag_dr_regs #(.IDCODE(IDCODE)) dut (
    .tck_i    (tck_i),
    .trst_ni  (trst_ni),
    .reset_i  (reset_i),
    .tap      (tap),
    .status_i (status_i),
    .data_o   (data_o)
  );

  initial tck_i = 1'b0;
  always #5 tck_i = ~tck_i;

  typedef struct {
    int          len;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model: plain arrays and integers
  int m_mem [16];
  int m_addr;
  int m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) $display("FAIL %s: got %h expected %h", name, act, expv);
    else              n_pass++;
  endtask

  // monitor: collects tdo bits of each shift burst
  logic [31:0] mon_acc;
  int          mon_cnt;
  initial begin
    mon_acc = '0;
    mon_cnt = 0;
  end

  always @(negedge tck_i) begin
    if (!trst_ni || reset_i) begin
      mon_acc = '0;
      mon_cnt = 0;
    end else if (tap.shift_i && !tap.capture_i && exp_q.size() > 0) begin
      mon_acc[mon_cnt] = tap.tdo_o;
      mon_cnt++;
      if (mon_cnt == exp_q[0].len) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, mon_acc, e.val);
        mon_acc = '0;
        mon_cnt = 0;
      end
    end
  end

  function automatic int dr_len(input logic [3:0] ir);
    return (ir == 4'b0001) ? 32 : 8;
  endfunction

  task automatic scan(input logic [3:0] ir, input int len, input logic [31:0] din,
                      input bit upd, input string name);
    logic [31:0] cap;
    logic [31:0] mask;
    bit          is_bypass;
    is_bypass = !(ir inside {4'b0001, 4'b0010, 4'b0011, 4'b0100});
    case (ir)
      4'b0001: cap = IDCODE;
      4'b0010: cap = 32'(status_i);
      4'b0011: cap = 32'(m_addr);
      4'b0100: cap = 32'(m_mem[m_addr]);
      default: cap = 32'h0;
    endcase
    mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    if (len > 0) exp_q.push_back('{len, cap & mask, name});

    tap.ir_i      = ir;
    tap.capture_i = 1'b1;
    @(posedge tck_i); #1;
    tap.capture_i = 1'b0;
    if (len > 0) tap.shift_i = 1'b1;
    for (int i = 0; i < len; i++) begin
      tap.tdi_i = din[i];
      @(posedge tck_i); #1;
    end
    tap.shift_i = 1'b0;
    tap.tdi_i   = 1'b0;
    if (upd) begin
      tap.update_i = 1'b1;
      @(posedge tck_i); #1;
      tap.update_i = 1'b0;
      case (ir)
        4'b0010: m_data = int'(din[7:0]);
        4'b0011: m_addr = int'(din[3:0]);
        4'b0100: begin
          m_mem[m_addr] = (len == 0) ? int'(cap[7:0]) : int'(din[7:0]);
          m_addr        = (m_addr + 1) % 16;
        end
        default: ;
      endcase
    end
    check({name, "_data_o"}, 32'(data_o), 32'(m_data));
    check({name, "_bypass"}, 32'(tap.bypass_o), 32'(is_bypass));
  endtask

  task automatic dump_mem(input string name);
    for (int a = 0; a < 16; a++) begin
      scan(4'b0011, 8, 32'(a), 1'b1, {name, "_seta"});
      scan(4'b0100, 8, 32'h0, 1'b0, {name, "_rd"});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tap.ir_i      = 4'b0000;
    tap.tdi_i     = 1'b0;
    tap.capture_i = 1'b0;
    tap.shift_i   = 1'b0;
    tap.update_i  = 1'b0;
    status_i      = 8'h00;
    reset_i       = 1'b0;
    trst_ni       = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_addr = 0;
    m_data = 0;

    #12;
    check("rst_data_o", 32'(data_o), 32'h0);
    check("rst_tdo", 32'(tap.tdo_o), 32'h0);
    check("rst_bypass", 32'(tap.bypass_o), 32'h1);
    @(posedge tck_i); #1;
    trst_ni = 1'b1;
    @(posedge tck_i); #1;

    scan(4'b0001, 32, 32'h0, 1'b0, "idcode");
    status_i = 8'h3C;
    scan(4'b0010, 8, 32'hA5, 1'b1, "userdata");
    check("userdata_a5", 32'(data_o), 32'hA5);
    scan(4'b0001, 32, 32'hDEAD_BEEF, 1'b1, "idcode_upd_noeffect");

    scan(4'b0011, 8, 32'hFF, 1'b1, "addr15");
    scan(4'b0100, 8, 32'h11, 1'b1, "wr11");
    scan(4'b0100, 8, 32'h22, 1'b1, "wr22");
    scan(4'b0011, 8, 32'h0, 1'b0, "addr_is1");
    scan(4'b0011, 8, 32'h0F, 1'b1, "seta15");
    scan(4'b0100, 8, 32'h0, 1'b0, "rd_mem15");
    scan(4'b0011, 8, 32'h00, 1'b1, "seta0");
    scan(4'b0100, 8, 32'h0, 1'b0, "rd_mem0");

    scan(4'b1111, 8, 32'h5A, 1'b1, "byp_f");
    check("byp_f_tdo", 32'(tap.tdo_o), 32'h0);
    scan(4'b0101, 8, 32'hC3, 1'b1, "byp_5");
    scan(4'b0011, 8, 32'h0, 1'b0, "addr_after_byp");
    scan(4'b0100, 8, 32'h0, 1'b0, "mem_after_byp");

    scan(4'b0100, 0, 32'h0, 1'b1, "cap_upd_rewrite");
    scan(4'b0011, 8, 32'h0, 1'b0, "addr_after_rewrite");

    tap.ir_i      = 4'b0100;
    tap.capture_i = 1'b1;
    tap.update_i  = 1'b1;
    @(posedge tck_i); #1;
    tap.capture_i = 1'b0;
    tap.update_i  = 1'b0;
    scan(4'b0011, 8, 32'h0, 1'b0, "addr_after_cap_and_upd");

    for (int n = 0; n < 40; n++) begin
      logic [3:0] ir;
      case ($urandom_range(0, 6))
        0: ir = 4'b0001;
        1: ir = 4'b0010;
        2: ir = 4'b0011;
        3, 4: ir = 4'b0100;
        5: ir = 4'b0000;
        default: ir = 4'($urandom_range(5, 15));
      endcase
      status_i = 8'($urandom);
      scan(ir, dr_len(ir), $urandom, 1'($urandom), "rnd");
    end

    // sync reset in the middle of a MEMDATA shift, with update also requested
    tap.ir_i      = 4'b0100;
    tap.capture_i = 1'b1;
    @(posedge tck_i); #1;
    tap.capture_i = 1'b0;
    tap.shift_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tap.tdi_i = 1'b1;
      @(posedge tck_i); #1;
    end
    reset_i      = 1'b1;
    tap.update_i = 1'b1;
    @(posedge tck_i); #1;
    reset_i      = 1'b0;
    tap.shift_i  = 1'b0;
    tap.update_i = 1'b0;
    tap.tdi_i    = 1'b0;
    m_addr = 0;
    m_data = 0;
    check("sync_rst_tdo", 32'(tap.tdo_o), 32'h0);
    check("sync_rst_data_o", 32'(data_o), 32'h0);
    scan(4'b0011, 8, 32'h0, 1'b0, "sync_rst_addr");
    dump_mem("after_sync_rst");

    tap.ir_i = 4'b0001;
    trst_ni  = 1'b0;
    #2;
    check("trst_tdo", 32'(tap.tdo_o), 32'h0);
    check("trst_data_o", 32'(data_o), 32'h0);
    @(posedge tck_i); #1;
    trst_ni = 1'b1;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_addr = 0;
    m_data = 0;
    dump_mem("after_trst");

    @(posedge tck_i); #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
